// File: rtl/half_adder_if.sv
// Operand/result bundle for the half adder: A/B with their qualifier in one
// direction, S/C with their qualifier in the other.
interface half_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic             out_valid;

  // Producer of operands, consumer of results.
  modport master (
    output a, b, in_valid,
    input  s, c, out_valid
  );

  // The half adder itself.
  modport slave (
    input  a, b, in_valid,
    output s, c, out_valid
  );
endinterface

// File: rtl/half_adder.sv
// Bit-sliced clocked half adder: WIDTH independent lanes, each producing
// sum = a ^ b and carry = a & b, behind LATENCY output register stages
// (0 = purely combinational). A valid bit travels alongside the data.
module half_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 1
) (
  input logic        clk,
  input logic        rst,
  half_adder_if.slave bus
);

  // Reject unsupported configurations at elaboration time.
  if (WIDTH < 1 || LATENCY > 4) begin : gen_bad_params
    $error("half_adder: WIDTH must be >= 1 and LATENCY must be 0..4");
  end

  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;

  // Per-lane arithmetic; lanes never interact.
  always_comb begin
    sum_in   = bus.a ^ bus.b;
    carry_in = bus.a & bus.b;
  end

  if (LATENCY == 0) begin : gen_comb
    // Straight-through path; reset still forces everything low.
    always_comb begin
      bus.s         = '0;
      bus.c         = '0;
      bus.out_valid = 1'b0;
      if (!rst) begin
        bus.s         = sum_in;
        bus.c         = carry_in;
        bus.out_valid = bus.in_valid;
      end
    end
  end else begin : gen_pipe
    logic [WIDTH-1:0]   sum_q   [LATENCY];
    logic [WIDTH-1:0]   carry_q [LATENCY];
    logic [LATENCY-1:0] valid_q;

    // Valid shifts every cycle; data stages only load when the valid bit at
    // their input is set, so outputs keep the last valid result otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < LATENCY; k++) begin
          sum_q[k]   <= '0;
          carry_q[k] <= '0;
          valid_q[k] <= 1'b0;
        end
      end else begin
        valid_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          sum_q[0]   <= sum_in;
          carry_q[0] <= carry_in;
        end
        for (int unsigned k = 1; k < LATENCY; k++) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            sum_q[k]   <= sum_q[k-1];
            carry_q[k] <= carry_q[k-1];
          end
        end
      end
    end

    // Last stage drives the outputs.
    always_comb begin
      bus.s         = sum_q[LATENCY-1];
      bus.c         = carry_q[LATENCY-1];
      bus.out_valid = valid_q[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Directed test of half_adder in three configurations: default (1 lane,
// 1 stage), 4 lanes with 3 stages, and the combinational variant.
module tb_half_adder;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_errors;

  half_adder_if #(.WIDTH(1)) ha1 ();
  half_adder_if #(.WIDTH(4)) ha4 ();
  half_adder_if #(.WIDTH(1)) ha0 ();

  half_adder #(.WIDTH(1), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ha1.slave));
  half_adder #(.WIDTH(4), .LATENCY(3)) u_dut4 (.clk(clk), .rst(rst), .bus(ha4.slave));
  half_adder #(.WIDTH(1), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(ha0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors for the default instance: a, b, expected s, expected c.
  logic [3:0] vec [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    vec[0] = 4'b00_00;
    vec[1] = 4'b01_10;
    vec[2] = 4'b10_10;
    vec[3] = 4'b11_01;
    vec[4] = 4'b00_00;

    rst = 1'b1;
    ha1.a = 1'b0; ha1.b = 1'b0; ha1.in_valid = 1'b1;
    ha4.a = '0;   ha4.b = '0;   ha4.in_valid = 1'b0;
    ha0.a = 1'b1; ha0.b = 1'b1; ha0.in_valid = 1'b1;

    // Reset held two cycles.
    step();
    step();
    check("rst_s", {3'b0, ha1.s}, 4'd0);
    check("rst_c", {3'b0, ha1.c}, 4'd0);
    check("rst_v", {3'b0, ha1.out_valid}, 4'd0);
    check("rst_v4", {3'b0, ha4.out_valid}, 4'd0);
    check("rst_s4", ha4.s, 4'd0);
    check("rst_c0", {3'b0, ha0.c}, 4'd0);
    check("rst_v0", {3'b0, ha0.out_valid}, 4'd0);

    // Release: valid appears one edge later.
    rst = 1'b0;
    step();
    check("rel_v", {3'b0, ha1.out_valid}, 4'd1);
    check("rel_s", {3'b0, ha1.s}, 4'd0);

    // Truth table, each vector held 10 cycles.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] v;
      logic [3:0] pv;
      v  = vec[i];
      pv = (i == 0) ? 4'b0000 : vec[i-1];
      ha1.a = v[3];
      ha1.b = v[2];
      #1;
      check($sformatf("tt%0d_pre_s", i), {3'b0, ha1.s}, {3'b0, pv[1]});
      check($sformatf("tt%0d_pre_c", i), {3'b0, ha1.c}, {3'b0, pv[0]});
      step();
      check($sformatf("tt%0d_s", i), {3'b0, ha1.s}, {3'b0, v[1]});
      check($sformatf("tt%0d_c", i), {3'b0, ha1.c}, {3'b0, v[0]});
      for (int j = 0; j < 9; j++) step();
      check($sformatf("tt%0d_hold_s", i), {3'b0, ha1.s}, {3'b0, v[1]});
      check($sformatf("tt%0d_hold_c", i), {3'b0, ha1.c}, {3'b0, v[0]});
      check($sformatf("tt%0d_v", i), {3'b0, ha1.out_valid}, 4'd1);
    end

    // Mid-stream reset flushes the result.
    ha1.a = 1'b1; ha1.b = 1'b1;
    step();
    check("mid_pre_c", {3'b0, ha1.c}, 4'd1);
    rst = 1'b1;
    step();
    check("mid_rst_s", {3'b0, ha1.s}, 4'd0);
    check("mid_rst_c", {3'b0, ha1.c}, 4'd0);
    check("mid_rst_v", {3'b0, ha1.out_valid}, 4'd0);
    rst = 1'b0;
    step();
    check("mid_post_s", {3'b0, ha1.s}, 4'd0);
    check("mid_post_c", {3'b0, ha1.c}, 4'd1);
    check("mid_post_v", {3'b0, ha1.out_valid}, 4'd1);

    // Invalid input holds the last valid result.
    ha1.a = 1'b1; ha1.b = 1'b0;
    step();
    check("inv_pre_s", {3'b0, ha1.s}, 4'd1);
    ha1.a = 1'b1; ha1.b = 1'b1; ha1.in_valid = 1'b0;
    step();
    check("inv_v", {3'b0, ha1.out_valid}, 4'd0);
    check("inv_s", {3'b0, ha1.s}, 4'd1);
    check("inv_c", {3'b0, ha1.c}, 4'd0);
    step();
    check("inv_hold_s", {3'b0, ha1.s}, 4'd1);
    check("inv_hold_c", {3'b0, ha1.c}, 4'd0);

    // Four lanes, three stages.
    ha4.a = 4'b1100; ha4.b = 4'b1010; ha4.in_valid = 1'b1;
    step();
    ha4.a = 4'b1111; ha4.b = 4'b1111; ha4.in_valid = 1'b0;
    check("w4_v1", {3'b0, ha4.out_valid}, 4'd0);
    step();
    check("w4_v2", {3'b0, ha4.out_valid}, 4'd0);
    check("w4_s2", ha4.s, 4'b0000);
    step();
    check("w4_v3", {3'b0, ha4.out_valid}, 4'd1);
    check("w4_s3", ha4.s, 4'b0110);
    check("w4_c3", ha4.c, 4'b1000);
    step();
    check("w4_v4", {3'b0, ha4.out_valid}, 4'd0);
    check("w4_hold_s", ha4.s, 4'b0110);
    check("w4_hold_c", ha4.c, 4'b1000);

    // Combinational variant.
    ha0.a = 1'b1; ha0.b = 1'b1; ha0.in_valid = 1'b1;
    #1;
    check("l0_s11", {3'b0, ha0.s}, 4'd0);
    check("l0_c11", {3'b0, ha0.c}, 4'd1);
    check("l0_v", {3'b0, ha0.out_valid}, 4'd1);
    ha0.b = 1'b0;
    #1;
    check("l0_s10", {3'b0, ha0.s}, 4'd1);
    check("l0_c10", {3'b0, ha0.c}, 4'd0);
    ha0.in_valid = 1'b0;
    #1;
    check("l0_inv", {3'b0, ha0.out_valid}, 4'd0);
    ha0.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("l0_rst_s", {3'b0, ha0.s}, 4'd0);
    check("l0_rst_c", {3'b0, ha0.c}, 4'd0);
    check("l0_rst_v", {3'b0, ha0.out_valid}, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
